// File: rtl/counter_read_latch.sv
// Counter read-back latch: freezes a 16-bit count for byte-wise host reads
// in LSB, MSB or LSB-then-MSB format.
module counter_read_latch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_write,
  input  logic [1:0] rw_mode,
  input  logic       latch_cmd,
  input  logic       rd_strobe,
  input  logic [7:0] count_high,
  input  logic [7:0] count_low,
  output logic [7:0] data_out,
  output logic       latched,
  output logic       msb_next
);

  // state  | meaning
  // FOLLOW | OL tracks the live count, no latch pending
  // HOLD1  | OL frozen, one byte read left before release
  // HOLD2  | OL frozen, two byte reads left before release
  typedef enum logic [1:0] {
    FOLLOW = 2'd0,
    HOLD1  = 2'd1,
    HOLD2  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_ol;
  logic [15:0] w_ol_nxt;
  logic [1:0]  r_mode;
  logic [1:0]  w_mode_nxt;
  logic        r_ptr;
  logic        w_ptr_nxt;
  logic        w_mode_load;
  logic        w_msb_sel;
  logic [15:0] w_count;

  assign w_count     = {count_high, count_low};
  assign w_mode_load = mode_write && (rw_mode != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FOLLOW;
      r_ol    <= 16'h0000;
      r_mode  <= 2'b11;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ol    <= w_ol_nxt;
      r_mode  <= w_mode_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ol_nxt    = r_ol;
    w_mode_nxt  = r_mode;
    w_ptr_nxt   = r_ptr;

    if (w_mode_load) begin
      w_mode_nxt  = rw_mode;
      w_ptr_nxt   = 1'b0;
      w_state_nxt = FOLLOW;
      w_ol_nxt    = w_count;
    end else begin
      if (rd_strobe && (r_mode == 2'b11)) begin
        w_ptr_nxt = ~r_ptr;
      end
      unique case (r_state)
        FOLLOW: begin
          w_ol_nxt = w_count;
          // Hold depth uses the post-read pointer so a same-cycle read counts.
          if (latch_cmd) begin
            if ((r_mode == 2'b11) && !w_ptr_nxt) w_state_nxt = HOLD2;
            else                                 w_state_nxt = HOLD1;
          end
        end
        HOLD1: begin
          if (rd_strobe) w_state_nxt = FOLLOW;
        end
        HOLD2: begin
          if (rd_strobe) w_state_nxt = HOLD1;
        end
        default: w_state_nxt = FOLLOW;
      endcase
    end
  end

  assign w_msb_sel = (r_mode == 2'b10) || ((r_mode == 2'b11) && r_ptr);
  assign data_out  = w_msb_sel ? r_ol[15:8] : r_ol[7:0];
  assign msb_next  = w_msb_sel;
  assign latched   = (r_state != FOLLOW);

endmodule

// File: tb/tb_counter_read_latch.sv
// Directed and randomized bench for counter_read_latch, checked against a
// reads-remaining model of the latch.
module tb_counter_read_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode_write;
  logic [1:0] rw_mode;
  logic       latch_cmd;
  logic       rd_strobe;
  logic [7:0] count_high;
  logic [7:0] count_low;
  logic [7:0] data_out;
  logic       latched;
  logic       msb_next;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frozen/live value, format, byte pointer, reads left.
  logic [15:0] m_ol;
  logic [1:0]  m_mode;
  logic        m_ptr;
  int          m_left;

  counter_read_latch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_write (mode_write),
    .rw_mode    (rw_mode),
    .latch_cmd  (latch_cmd),
    .rd_strobe  (rd_strobe),
    .count_high (count_high),
    .count_low  (count_low),
    .data_out   (data_out),
    .latched    (latched),
    .msb_next   (msb_next)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_msb();
    return (m_mode == 2'b10) || (m_mode == 2'b11 && m_ptr);
  endfunction

  task automatic chk_model(input string tag);
    logic [7:0] exp_d;
    exp_d = exp_msb() ? m_ol[15:8] : m_ol[7:0];
    chk({tag, "_dout"}, {8'h00, data_out}, {8'h00, exp_d});
    chk({tag, "_latched"}, {15'h0, latched}, {15'h0, (m_left != 0)});
    chk({tag, "_msbnext"}, {15'h0, msb_next}, {15'h0, exp_msb()});
  endtask

  task automatic model_reset();
    m_ol = 16'h0000; m_mode = 2'b11; m_ptr = 1'b0; m_left = 0;
  endtask

  task automatic model_edge(input logic mw, input logic [1:0] rw, input logic lc,
                            input logic rd, input logic [15:0] cnt);
    if (mw && rw != 2'b00) begin
      m_mode = rw; m_ptr = 1'b0; m_left = 0; m_ol = cnt;
    end else begin
      if (rd && m_mode == 2'b11) m_ptr = ~m_ptr;
      if (m_left == 0) begin
        m_ol = cnt;
        // Bytes still owed: both halves only when an LSB-first pair is pending.
        if (lc) m_left = (m_mode == 2'b11 && !m_ptr) ? 2 : 1;
      end else if (rd) begin
        m_left = m_left - 1;
      end
    end
  endtask

  task automatic step(input string tag, input logic mw, input logic [1:0] rw,
                      input logic lc, input logic rd, input logic [15:0] cnt);
    mode_write = mw; rw_mode = rw; latch_cmd = lc; rd_strobe = rd;
    count_high = cnt[15:8]; count_low = cnt[7:0];
    @(posedge clk);
    model_edge(mw, rw, lc, rd, cnt);
    #1;
    mode_write = 1'b0; latch_cmd = 1'b0; rd_strobe = 1'b0;
    chk_model(tag);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_rst_dout"}, {8'h00, data_out}, 16'h0000);
    chk({tag, "_rst_latched"}, {15'h0, latched}, 16'h0000);
    chk({tag, "_rst_msbnext"}, {15'h0, msb_next}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] cnt;
    rst_n = 1'b0; mode_write = 1'b0; rw_mode = 2'b00; latch_cmd = 1'b0;
    rd_strobe = 1'b0; count_high = 8'h00; count_low = 8'h00;
    model_reset();
    #3;
    chk("reset_dout", {8'h00, data_out}, 16'h0000);
    chk("reset_latched", {15'h0, latched}, 16'h0000);
    chk("reset_msbnext", {15'h0, msb_next}, 16'h0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Live read in LSB-then-MSB format.
    step("r32_mw", 1, 2'b11, 0, 0, 16'h1234);
    chk("r32_first", {8'h00, data_out}, 16'h0034);
    step("r32_rd1", 0, 2'b00, 0, 1, 16'h1234);
    chk("r32_second", {8'h00, data_out}, 16'h0012);
    step("r32_rd2", 0, 2'b00, 0, 1, 16'h1234);

    // Latched value survives count changes until both bytes are read.
    step("r33_latch", 0, 2'b00, 1, 0, 16'hABCD);
    chk("r33_lo", {8'h00, data_out}, 16'h00CD);
    step("r33_rd1", 0, 2'b00, 0, 1, 16'h0001);
    chk("r33_hi", {8'h00, data_out}, 16'h00AB);
    chk("r33_held", {15'h0, latched}, 16'h0001);
    step("r33_rd2", 0, 2'b00, 0, 1, 16'h0001);
    chk("r33_release", {15'h0, latched}, 16'h0000);
    step("r33_follow", 0, 2'b00, 0, 0, 16'h0001);
    chk("r33_live", {8'h00, data_out}, 16'h0001);

    // Second latch while holding is ignored.
    step("r34_latch", 0, 2'b00, 1, 0, 16'h5555);
    step("r34_relatch", 0, 2'b00, 1, 0, 16'h1111);
    chk("r34_b1", {8'h00, data_out}, 16'h0055);
    step("r34_rd1", 0, 2'b00, 0, 1, 16'h1111);
    chk("r34_b2", {8'h00, data_out}, 16'h0055);
    step("r34_rd2", 0, 2'b00, 0, 1, 16'h1111);

    // Mode write mid-sequence releases the latch.
    step("r35_latch", 0, 2'b00, 1, 0, 16'h9876);
    chk("r35_lo", {8'h00, data_out}, 16'h0076);
    step("r35_rd1", 0, 2'b00, 0, 1, 16'h9876);
    step("r35_mw", 1, 2'b10, 0, 0, 16'h9876);
    step("r35_live", 0, 2'b00, 0, 0, 16'h4400);
    chk("r35_hi_live", {8'h00, data_out}, 16'h0044);
    chk("r35_msb", {15'h0, msb_next}, 16'h0001);

    // Ignored rw_mode=00 write keeps mode 10.
    step("mw00", 1, 2'b00, 0, 0, 16'h7788);

    // LSB-only with same-cycle latch and read.
    step("r36_mw", 1, 2'b01, 0, 0, 16'h1111);
    step("r36_latchrd", 0, 2'b00, 1, 1, 16'h00FF);
    chk("r36_held", {15'h0, latched}, 16'h0001);
    chk("r36_val", {8'h00, data_out}, 16'h00FF);
    step("r36_rd", 0, 2'b00, 0, 1, 16'h0F0F);
    chk("r36_release", {15'h0, latched}, 16'h0000);

    // Reset mid-sequence discards latch and pointer.
    step("r37_mw", 1, 2'b11, 0, 0, 16'h4321);
    step("r37_latch", 0, 2'b00, 1, 0, 16'h4321);
    step("r37_rd1", 0, 2'b00, 0, 1, 16'h4321);
    pulse_reset("r37");
    step("r37_after", 0, 2'b00, 0, 0, 16'h2468);
    chk("r37_live", {8'h00, data_out}, 16'h0068);

    // Mode 11 latch+read on the same edge with ptr=0 leaves one byte owed.
    step("same11", 0, 2'b00, 1, 1, 16'hBEEF);
    step("same11_rd", 0, 2'b00, 0, 1, 16'h0000);

    for (int i = 0; i < 800; i++) begin
      cnt = 16'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset("rand");
      end else begin
        step("rand", ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), cnt);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
